// File: rtl/regfile_pkg.sv
// Shared constants for the register file with an integrated scoreboard.
// The optional same-cycle write-back forwarding is selected by the macro
// REGFILE_BYPASS_EN, which is used in regfile_sb.sv.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREGS      = 2 ** ADDR_W_DEF;
  localparam int REG_ZERO   = 0;

  // True when addr names the hard-wired zero register.
  function automatic logic is_reg_zero(input logic [ADDR_W_DEF-1:0] addr);
    return addr == ADDR_W_DEF'(REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Decode-stage bus between the core and regfile_sb: two read ports, one
// write-back port, and the issue handshake with flush and pending count.
//
// Issue handshake: an issue of iss_rd is accepted on a rising clk edge when
// iss_valid && iss_ready are both high in the cycle before it. iss_ready is
// combinational from iss_rd and the pending state only (never from
// iss_valid), so the master may look at it before deciding to raise
// iss_valid. A dropped issue (iss_ready low, or flush high) has no effect,
// and the master keeps iss_valid up if it still wants the issue.
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              busy1;
  logic              busy2;
  logic              we3;
  logic [ADDR_W-1:0] a3;
  logic [DATA_W-1:0] wd3;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_ready;
  logic              flush;
  logic [ADDR_W:0]   pend_cnt;

  // Core side: drives addresses, write-back and issue requests.
  modport master (
    output a1, a2, we3, a3, wd3, iss_valid, iss_rd, flush,
    input  rd1, rd2, busy1, busy2, iss_ready, pend_cnt
  );

  // Register file side.
  modport slave (
    input  a1, a2, we3, a3, wd3, iss_valid, iss_rd, flush,
    output rd1, rd2, busy1, busy2, iss_ready, pend_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pend bit per register, issue acceptance
// (write-after-write guard), flush and a registered count of pending bits.
// Register 0 is never marked pending.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_rd,
  output logic                   iss_ready,
  input  logic                   we3,
  input  logic [ADDR_W-1:0]      a3,
  input  logic                   flush,
  output logic [2**ADDR_W-1:0]   pend,
  output logic [ADDR_W:0]        pend_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W:0]     cnt_d;
  logic                iss_is_zero;
  logic                wb_is_zero;
  logic                set_en;
  logic                clr_en;

  // Acceptance and the set/clear strobes; a flush swallows the issue but the
  // handshake answer itself is still driven from the pend state.
  always_comb begin
    iss_is_zero = (iss_rd == ADDR_W'(REG_ZERO));
    wb_is_zero  = (a3 == ADDR_W'(REG_ZERO));
    iss_ready   = !pend_q[iss_rd] || iss_is_zero;
    set_en      = iss_valid && iss_ready && !iss_is_zero && !flush;
    // Only a write-back that actually clears a set bit lowers the count.
    clr_en      = we3 && !wb_is_zero && pend_q[a3];
  end

  // Next pend vector: clear from write-back first, then set from issue, so
  // an issue and write-back of the same register leave it pending. A set
  // and a clear never hit the same bit because set requires it to be clear.
  always_comb begin
    pend_d = pend_q;
    if (clr_en) begin
      pend_d[a3] = 1'b0;
    end
    if (set_en) begin
      pend_d[iss_rd] = 1'b1;
    end
    if (flush) begin
      pend_d = '0;
    end
    pend_d[REG_ZERO] = 1'b0;
  end

  // Next count: net change is -1, 0 or +1, and a flush empties it.
  always_comb begin
    cnt_d = cnt_q + (ADDR_W+1)'(set_en) - (ADDR_W+1)'(clr_en);
    if (flush) begin
      cnt_d = '0;
    end
  end

  // Pending state and count; asynchronous reset drops everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend     = pend_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with integrated scoreboard for the decode stage: two
// combinational read ports with busy flags, one clocked write-back port.
// Define REGFILE_BYPASS_EN to forward a same-cycle write-back to a reader
// (data = wd3, busy = 0); otherwise the new value and cleared busy show the
// cycle after the write-back.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic      clk,
  input  logic      reset,
  regfile_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   rf [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic                wb_en;
  logic                iss_ready;
  logic [ADDR_W:0]     pend_cnt;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .iss_ready (iss_ready),
    .we3       (bus.we3),
    .a3        (bus.a3),
    .flush     (bus.flush),
    .pend      (pend),
    .pend_cnt  (pend_cnt)
  );

  assign bus.iss_ready = iss_ready;
  assign bus.pend_cnt  = pend_cnt;

  // Register 0 is never written, so it keeps its reset value of zero.
  assign wb_en = bus.we3 && (bus.a3 != ADDR_W'(REG_ZERO));

  // Storage array; asynchronous reset clears every register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_en) begin
      rf[bus.a3] <= bus.wd3;
    end
  end

  // Read port 1: zero register reads 0 and is never busy.
  always_comb begin
    bus.rd1   = '0;
    bus.busy1 = 1'b0;
    if (bus.a1 != ADDR_W'(REG_ZERO)) begin
      bus.rd1   = rf[bus.a1];
      bus.busy1 = pend[bus.a1];
`ifdef REGFILE_BYPASS_EN
      if (bus.we3 && (bus.a3 == bus.a1)) begin
        bus.rd1   = bus.wd3;
        bus.busy1 = 1'b0;
      end
`else
`endif
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    bus.rd2   = '0;
    bus.busy2 = 1'b0;
    if (bus.a2 != ADDR_W'(REG_ZERO)) begin
      bus.rd2   = rf[bus.a2];
      bus.busy2 = pend[bus.a2];
`ifdef REGFILE_BYPASS_EN
      if (bus.we3 && (bus.a3 == bus.a2)) begin
        bus.rd2   = bus.wd3;
        bus.busy2 = 1'b0;
      end
`else
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an array-based model.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2 ** AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_rf   [NR];
  bit            m_pend [NR];
  bit            m_rdy;

  function automatic bit m_ready(input logic [AW-1:0] r);
    return (r == 0) || !m_pend[r];
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.we3 && bus.a3 == a) return bus.wd3;
`endif
    return m_rf[a];
  endfunction

  function automatic bit m_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (bus.we3 && bus.a3 == a) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        m_rf[i]   = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      m_rdy = m_ready(bus.iss_rd);
      if (bus.we3 && bus.a3 != 0) begin
        m_rf[bus.a3]   = bus.wd3;
        m_pend[bus.a3] = 1'b0;
      end
      if (bus.flush) begin
        for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
      end else if (bus.iss_valid && m_rdy && bus.iss_rd != 0) begin
        m_pend[bus.iss_rd] = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_rd1",       64'(bus.rd1),       64'(m_rd(bus.a1)));
      chk("cyc_rd2",       64'(bus.rd2),       64'(m_rd(bus.a2)));
      chk("cyc_busy1",     64'(bus.busy1),     64'(m_busy(bus.a1)));
      chk("cyc_busy2",     64'(bus.busy2),     64'(m_busy(bus.a2)));
      chk("cyc_iss_ready", 64'(bus.iss_ready), 64'(m_ready(bus.iss_rd)));
      chk("cyc_pend_cnt",  64'(bus.pend_cnt),  64'(m_count()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we3       = 1'b0;
    bus.iss_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we3 = 1'b1;
    bus.a3  = a;
    bus.wd3 = d;
  endtask

  task automatic issue(input logic [AW-1:0] r);
    bus.iss_valid = 1'b1;
    bus.iss_rd    = r;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR-1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic rand_cycle();
    bus.we3       = ($urandom_range(0, 1) == 1);
    bus.a3        = pick_addr();
    bus.wd3       = $urandom;
    bus.iss_valid = ($urandom_range(0, 2) != 0);
    bus.iss_rd    = pick_addr();
    bus.flush     = ($urandom_range(0, 39) == 0);
    bus.a1        = ($urandom_range(0, 3) == 0) ? bus.a3 : pick_addr();
    bus.a2        = ($urandom_range(0, 3) == 0) ? bus.a3 : pick_addr();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    reset   = 1'b0;
    idle();
    bus.a1  = '0;
    bus.a2  = '0;
    bus.a3  = '0;
    bus.wd3 = '0;
    bus.iss_rd = '0;
    #1 reset = 1'b1;
    step();
    step();
    reset  = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("init_pend_cnt",  64'(bus.pend_cnt),  64'd0);
    chk("init_iss_ready", 64'(bus.iss_ready), 64'd1);

    // basic write/read
    wb(5, 32'hDEADBEEF);
    step(); idle();
    bus.a1 = 5;
    #1;
    chk("basic_rd1",   64'(bus.rd1),   64'hDEADBEEF);
    chk("basic_busy1", 64'(bus.busy1), 64'd0);
    wb(0, 32'h1234);
    bus.a1 = 0;
    #1 chk("r0_same_cycle", 64'(bus.rd1), 64'd0);
    step(); idle();
    #1 chk("r0_after", 64'(bus.rd1), 64'd0);

    // issue r7, then WAW attempt
    issue(7);
    #1 chk("iss7_ready", 64'(bus.iss_ready), 64'd1);
    step(); idle();
    bus.a1 = 7;
    issue(7);
    #1;
    chk("iss7_busy1",    64'(bus.busy1),     64'd1);
    chk("iss7_cnt",      64'(bus.pend_cnt),  64'd1);
    chk("iss7_waw_rdy",  64'(bus.iss_ready), 64'd0);
    step(); idle();
    #1 chk("iss7_waw_cnt", 64'(bus.pend_cnt), 64'd1);

    // write back r7
    wb(7, 32'h55);
    step(); idle();
    #1;
    chk("wb7_cnt",   64'(bus.pend_cnt),  64'd0);
    chk("wb7_ready", 64'(bus.iss_ready), 64'd1);
    chk("wb7_rd1",   64'(bus.rd1),       64'h55);
    chk("wb7_busy1", 64'(bus.busy1),     64'd0);

    // r3 pending, second issue refused
    issue(3);
    step();
    #1 chk("iss3_waw_rdy", 64'(bus.iss_ready), 64'd0);
    step(); idle();
    bus.a1 = 3;
    #1;
    chk("iss3_cnt",   64'(bus.pend_cnt), 64'd1);
    chk("iss3_busy1", 64'(bus.busy1),    64'd1);
    wb(3, 32'h33);
    step(); idle();

    // issue r4 while r9's write-back clears: net zero
    issue(9);
    step(); idle();
    issue(4);
    wb(9, 32'h99);
    step(); idle();
    #1 chk("simul_cnt", 64'(bus.pend_cnt), 64'd1);

    // issue and write-back of r9 in the same cycle: issue wins
    issue(9);
    wb(9, 32'h999);
    #1 chk("same9_ready", 64'(bus.iss_ready), 64'd1);
    step(); idle();
    bus.a1 = 9;
    #1;
    chk("same9_busy1", 64'(bus.busy1),    64'd1);
    chk("same9_rd1",   64'(bus.rd1),      64'h999);
    chk("same9_cnt",   64'(bus.pend_cnt), 64'd2);

    // same-cycle write-back vs read on port 2, r12 pending beforehand
    issue(12);
    step(); idle();
    bus.a2 = 12;
    wb(12, 32'hA5A5);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd2",   64'(bus.rd2),   64'hA5A5);
    chk("byp_busy2", 64'(bus.busy2), 64'd0);
`else
    chk("nobyp_rd2",   64'(bus.rd2),   64'd0);
    chk("nobyp_busy2", 64'(bus.busy2), 64'd1);
`endif
    step(); idle();
    #1;
    chk("byp_next_rd2",   64'(bus.rd2),   64'hA5A5);
    chk("byp_next_busy2", 64'(bus.busy2), 64'd0);

    // flush with a concurrent issue and write-back
    issue(5);
    step(); idle();
    #1 chk("pre_flush_cnt", 64'(bus.pend_cnt), 64'd3);
    bus.flush = 1'b1;
    issue(2);
    wb(4, 32'h77);
    #1 chk("flush_iss_ready", 64'(bus.iss_ready), 64'd1);
    step(); idle();
    bus.a1 = 4;
    bus.a2 = 2;
    #1;
    chk("flush_rd4",   64'(bus.rd1),      64'h77);
    chk("flush_busy4", 64'(bus.busy1),    64'd0);
    chk("flush_busy2", 64'(bus.busy2),    64'd0);
    chk("flush_cnt",   64'(bus.pend_cnt), 64'd0);
    bus.a1 = 9;
    bus.a2 = 5;
    #1;
    chk("flush_busy9", 64'(bus.busy1), 64'd0);
    chk("flush_busy5", 64'(bus.busy2), 64'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rand_cycle();
      step();
    end
    idle();

    // asynchronous reset in the middle of a cycle with live state
    wb(6, 32'hCAFE);
    issue(10);
    step(); idle();
    bus.a1     = 6;
    bus.a2     = 10;
    bus.iss_rd = 10;
    #1;
    chk("pre_rst_rd1",   64'(bus.rd1),       64'hCAFE);
    chk("pre_rst_busy2", 64'(bus.busy2),     64'd1);
    chk("pre_rst_ready", 64'(bus.iss_ready), 64'd0);
    #1 reset = 1'b1;
    #1;
    chk("rst_rd1",   64'(bus.rd1),       64'd0);
    chk("rst_rd2",   64'(bus.rd2),       64'd0);
    chk("rst_busy2", 64'(bus.busy2),     64'd0);
    chk("rst_cnt",   64'(bus.pend_cnt),  64'd0);
    chk("rst_ready", 64'(bus.iss_ready), 64'd1);
    step();
    reset = 1'b0;
    step();
    step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
